// File: rtl/mem_pkg.sv
// Shared opcodes, bus direction encodings and FSM states for the memory bus arbiter.
package mem_pkg;
    localparam logic [3:0] OP_LDR   = 4'b1101;
    localparam logic [3:0] OP_STR   = 4'b1100;
    localparam logic       RW_READ  = 1'b1;
    localparam logic       RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;
endpackage

// File: rtl/mem_wait_counter.sv
// Loadable wait-state down-counter; zero flags the final MemEn cycle of an access.
module mem_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = CNT_W'(WAIT_CYCLES - 1);
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch and load/store ports,
// one fixed-latency access at a time, with registered bus outputs and grant pulses.
module mem_bus_arbiter
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  FetchReq,
    input  logic [DATA_WIDTH-1:0] FetchAddr,
    output logic                  FetchGnt,
    output logic [DATA_WIDTH-1:0] FetchData,
    input  logic                  DataReq,
    input  logic [3:0]            DataOpcode,
    input  logic [DATA_WIDTH-1:0] DataAddr,
    input  logic [DATA_WIDTH-1:0] DataWrData,
    output logic                  DataGnt,
    output logic [DATA_WIDTH-1:0] DataRdData,
    output logic                  DataErr,
    output logic [DATA_WIDTH-1:0] AddressBus,
    output logic [DATA_WIDTH-1:0] DataBusOut,
    output logic                  RW,
    output logic                  MemEn,
    input  logic [DATA_WIDTH-1:0] MemRdData,
    output logic                  Busy
);
    state_t                state_q, state_d;
    logic                  last_data_q, last_data_d;   // 1 = data port served last
    logic                  sel_data_q, sel_data_d;     // winner of the current access
    logic                  fetch_gnt_q, fetch_gnt_d;
    logic                  data_gnt_q, data_gnt_d;
    logic                  data_err_q, data_err_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rw_q, rw_d;
    logic                  mem_en_q, mem_en_d;
    logic                  busy_q, busy_d;

    logic cnt_load, cnt_zero, pick_data, op_valid;

    mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
        .clk   (Clk),
        .reset (Reset),
        .load  (cnt_load),
        .en    (state_q == ACCESS),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        sel_data_d   = sel_data_q;
        fetch_gnt_d  = 1'b0;
        data_gnt_d   = 1'b0;
        data_err_d   = 1'b0;
        fetch_data_d = fetch_data_q;
        data_rd_d    = data_rd_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        rw_d         = rw_q;
        mem_en_d     = mem_en_q;
        cnt_load     = 1'b0;
        pick_data    = DataReq && (!FetchReq || !last_data_q);
        op_valid     = (DataOpcode == OP_LDR) || (DataOpcode == OP_STR);

        case (state_q)
            IDLE: begin
                if (FetchReq || DataReq) begin
                    if (pick_data && !op_valid) begin
                        // Bad opcode never touches the bus; answer immediately.
                        state_d     = RESP;
                        data_gnt_d  = 1'b1;
                        data_err_d  = 1'b1;
                        last_data_d = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        sel_data_d = pick_data;
                        mem_en_d   = 1'b1;
                        cnt_load   = 1'b1;
                        if (pick_data) begin
                            addr_d = DataAddr;
                            if (DataOpcode == OP_STR) begin
                                rw_d   = RW_WRITE;
                                dout_d = DataWrData;
                            end else begin
                                rw_d   = RW_READ;
                                dout_d = '0;
                            end
                        end else begin
                            addr_d = FetchAddr;
                            rw_d   = RW_READ;
                            dout_d = '0;
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    if (rw_q == RW_READ) begin
                        if (sel_data_q)
                            data_rd_d = MemRdData;
                        else
                            fetch_data_d = MemRdData;
                    end
                    state_d     = RESP;
                    mem_en_d    = 1'b0;
                    addr_d      = '0;
                    dout_d      = '0;
                    rw_d        = RW_READ;
                    fetch_gnt_d = !sel_data_q;
                    data_gnt_d  = sel_data_q;
                    last_data_d = sel_data_q;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b0;
            sel_data_q   <= 1'b0;
            fetch_gnt_q  <= 1'b0;
            data_gnt_q   <= 1'b0;
            data_err_q   <= 1'b0;
            fetch_data_q <= '0;
            data_rd_q    <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            rw_q         <= RW_READ;
            mem_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            sel_data_q   <= sel_data_d;
            fetch_gnt_q  <= fetch_gnt_d;
            data_gnt_q   <= data_gnt_d;
            data_err_q   <= data_err_d;
            fetch_data_q <= fetch_data_d;
            data_rd_q    <= data_rd_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            rw_q         <= rw_d;
            mem_en_q     <= mem_en_d;
            busy_q       <= busy_d;
        end
    end

    assign FetchGnt   = fetch_gnt_q;
    assign FetchData  = fetch_data_q;
    assign DataGnt    = data_gnt_q;
    assign DataRdData = data_rd_q;
    assign DataErr    = data_err_q;
    assign AddressBus = addr_q;
    assign DataBusOut = dout_q;
    assign RW         = rw_q;
    assign MemEn      = mem_en_q;
    assign Busy       = busy_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=1 instance.
module tb_mem_bus_arbiter;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        FetchReq, DataReq;
    logic [31:0] FetchAddr, DataAddr, DataWrData, MemRdData;
    logic [3:0]  DataOpcode;
    logic        FetchGnt, DataGnt, DataErr, RW, MemEn, Busy;
    logic [31:0] FetchData, DataRdData, AddressBus, DataBusOut;

    logic        b_DataReq;
    logic [3:0]  b_DataOpcode;
    logic [31:0] b_DataAddr, b_MemRdData;
    logic        b_FetchGnt, b_DataGnt, b_DataErr, b_RW, b_MemEn, b_Busy;
    logic [31:0] b_FetchData, b_DataRdData, b_AddressBus, b_DataBusOut;

    typedef struct {
        bit          is_data;
        bit          err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 Clk = ~Clk;

    mem_bus_arbiter #(.WAIT_CYCLES(2), .DATA_WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt), .FetchData(FetchData),
        .DataReq(DataReq), .DataOpcode(DataOpcode), .DataAddr(DataAddr), .DataWrData(DataWrData),
        .DataGnt(DataGnt), .DataRdData(DataRdData), .DataErr(DataErr),
        .AddressBus(AddressBus), .DataBusOut(DataBusOut), .RW(RW), .MemEn(MemEn),
        .MemRdData(MemRdData), .Busy(Busy)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(1), .DATA_WIDTH(32)) dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .FetchReq(1'b0), .FetchAddr(32'h0), .FetchGnt(b_FetchGnt), .FetchData(b_FetchData),
        .DataReq(b_DataReq), .DataOpcode(b_DataOpcode), .DataAddr(b_DataAddr), .DataWrData(32'h0),
        .DataGnt(b_DataGnt), .DataRdData(b_DataRdData), .DataErr(b_DataErr),
        .AddressBus(b_AddressBus), .DataBusOut(b_DataBusOut), .RW(b_RW), .MemEn(b_MemEn),
        .MemRdData(b_MemRdData), .Busy(b_Busy)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (FetchGnt !== 1'b0 || DataGnt !== 1'b0 || DataErr !== 1'b0)
            $display("FAIL rst_gnt got %b%b%b exp 000", FetchGnt, DataGnt, DataErr); else pass_cnt++;
        total_cnt++; if (FetchData !== 32'h0 || DataRdData !== 32'h0)
            $display("FAIL rst_data got %h %h exp 0 0", FetchData, DataRdData); else pass_cnt++;
        total_cnt++; if (AddressBus !== 32'h0 || DataBusOut !== 32'h0 || RW !== 1'b1 || MemEn !== 1'b0 || Busy !== 1'b0)
            $display("FAIL rst_bus got a=%h d=%h rw=%b en=%b busy=%b exp 0 0 1 0 0", AddressBus, DataBusOut, RW, MemEn, Busy); else pass_cnt++;
        Reset = 1'b0;
    endtask

    task automatic test_fetch_only;
        MemRdData = 32'hE3A01005;
        FetchAddr = 32'h00000040;
        FetchReq  = 1'b1;
        sb.push_back('{is_data: 1'b0, err: 1'b0, data: 32'hE3A01005});
        for (int c = 1; c <= 2; c++) begin
            tick();
            total_cnt++; if (MemEn !== 1'b1 || AddressBus !== 32'h40 || RW !== 1'b1 || Busy !== 1'b1)
                $display("FAIL fetch_access_c%0d got en=%b a=%h rw=%b busy=%b exp 1 40 1 1", c, MemEn, AddressBus, RW, Busy); else pass_cnt++;
            total_cnt++; if (FetchGnt !== 1'b0)
                $display("FAIL fetch_early_gnt_c%0d got %b exp 0", c, FetchGnt); else pass_cnt++;
        end
        tick();
        FetchReq = 1'b0;
        total_cnt++; if (FetchGnt !== 1'b1 || DataGnt !== 1'b0 || MemEn !== 1'b0 || AddressBus !== 32'h0)
            $display("FAIL fetch_gnt got fg=%b dg=%b en=%b a=%h exp 1 0 0 0", FetchGnt, DataGnt, MemEn, AddressBus); else pass_cnt++;
        e = sb.pop_front();
        total_cnt++; if (FetchData !== e.data)
            $display("FAIL fetch_data got %h exp %h", FetchData, e.data); else pass_cnt++;
        tick();
        total_cnt++; if (FetchGnt !== 1'b0 || Busy !== 1'b0)
            $display("FAIL fetch_idle got gnt=%b busy=%b exp 0 0", FetchGnt, Busy); else pass_cnt++;
    endtask

    task automatic test_round_robin;
        int gnt_seen, last_cycle, cyc;
        logic [31:0] vals [3];
        vals[0] = 32'h11110000; vals[1] = 32'h22220001; vals[2] = 32'h33330002;
        sb.push_back('{is_data: 1'b1, err: 1'b0, data: vals[0]});
        sb.push_back('{is_data: 1'b0, err: 1'b0, data: vals[1]});
        sb.push_back('{is_data: 1'b1, err: 1'b0, data: vals[2]});
        FetchAddr  = 32'h00000100;
        DataAddr   = 32'h00000200;
        DataOpcode = 4'b1101;
        MemRdData  = vals[0];
        FetchReq   = 1'b1;
        DataReq    = 1'b1;
        gnt_seen   = 0;
        last_cycle = 0;
        cyc        = 0;
        while (gnt_seen < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (FetchGnt || DataGnt) begin
                e = sb.pop_front();
                total_cnt++; if (DataGnt !== e.is_data || FetchGnt !== !e.is_data)
                    $display("FAIL rr_order_%0d got fg=%b dg=%b exp data=%0d", gnt_seen, FetchGnt, DataGnt, e.is_data); else pass_cnt++;
                total_cnt++; if ((e.is_data ? DataRdData : FetchData) !== e.data)
                    $display("FAIL rr_data_%0d got %h exp %h", gnt_seen, e.is_data ? DataRdData : FetchData, e.data); else pass_cnt++;
                if (gnt_seen > 0) begin
                    total_cnt++; if (cyc - last_cycle !== 4)
                        $display("FAIL rr_period_%0d got %0d exp 4", gnt_seen, cyc - last_cycle); else pass_cnt++;
                end
                last_cycle = cyc;
                gnt_seen++;
                if (gnt_seen < 3) MemRdData = vals[gnt_seen];
            end
        end
        total_cnt++; if (gnt_seen != 3)
            $display("FAIL rr_timeout got %0d grants exp 3", gnt_seen); else pass_cnt++;
        FetchReq = 1'b0;
        DataReq  = 1'b0;
        sb.delete();
        tick();
    endtask

    task automatic test_store;
        logic [31:0] rd_before;
        rd_before  = 32'h33330002;
        DataAddr   = 32'h12345678;
        DataWrData = 32'h9ABCDEF0;
        DataOpcode = 4'b1100;
        MemRdData  = 32'hDEADBEEF;
        DataReq    = 1'b1;
        sb.push_back('{is_data: 1'b1, err: 1'b0, data: rd_before});
        for (int c = 1; c <= 2; c++) begin
            tick();
            total_cnt++; if (MemEn !== 1'b1 || RW !== 1'b0 || AddressBus !== 32'h12345678 || DataBusOut !== 32'h9ABCDEF0)
                $display("FAIL str_access_c%0d got en=%b rw=%b a=%h d=%h exp 1 0 12345678 9abcdef0", c, MemEn, RW, AddressBus, DataBusOut); else pass_cnt++;
        end
        tick();
        DataReq = 1'b0;
        e = sb.pop_front();
        total_cnt++; if (DataGnt !== 1'b1 || DataErr !== 1'b0 || MemEn !== 1'b0 || RW !== 1'b1 || DataBusOut !== 32'h0)
            $display("FAIL str_gnt got dg=%b err=%b en=%b rw=%b d=%h exp 1 0 0 1 0", DataGnt, DataErr, MemEn, RW, DataBusOut); else pass_cnt++;
        total_cnt++; if (DataRdData !== e.data)
            $display("FAIL str_rd_unchanged got %h exp %h", DataRdData, e.data); else pass_cnt++;
        tick();
    endtask

    task automatic test_invalid_op;
        DataOpcode = 4'b0011;
        DataAddr   = 32'h00000300;
        DataReq    = 1'b1;
        sb.push_back('{is_data: 1'b1, err: 1'b1, data: 32'h33330002});
        tick();
        DataReq = 1'b0;
        e = sb.pop_front();
        total_cnt++; if (DataGnt !== 1'b1 || DataErr !== e.err || MemEn !== 1'b0 || FetchGnt !== 1'b0)
            $display("FAIL inv_gnt got dg=%b err=%b en=%b fg=%b exp 1 1 0 0", DataGnt, DataErr, MemEn, FetchGnt); else pass_cnt++;
        total_cnt++; if (DataRdData !== e.data)
            $display("FAIL inv_rd_unchanged got %h exp %h", DataRdData, e.data); else pass_cnt++;
        tick();
        total_cnt++; if (DataGnt !== 1'b0 || DataErr !== 1'b0 || Busy !== 1'b0 || MemEn !== 1'b0)
            $display("FAIL inv_idle got dg=%b err=%b busy=%b en=%b exp 0 0 0 0", DataGnt, DataErr, Busy, MemEn); else pass_cnt++;
    endtask

    task automatic test_reset_mid_access;
        int cyc;
        FetchAddr = 32'h00000080;
        MemRdData = 32'h0BADF00D;
        FetchReq  = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        total_cnt++; if (MemEn !== 1'b0 || RW !== 1'b1 || Busy !== 1'b0 || FetchGnt !== 1'b0 || AddressBus !== 32'h0)
            $display("FAIL midrst_idle got en=%b rw=%b busy=%b fg=%b a=%h exp 0 1 0 0 0", MemEn, RW, Busy, FetchGnt, AddressBus); else pass_cnt++;
        MemRdData = 32'h600DCAFE;
        sb.push_back('{is_data: 1'b0, err: 1'b0, data: 32'h600DCAFE});
        cyc = 0;
        while (!FetchGnt && cyc < 20) begin
            tick();
            cyc++;
        end
        FetchReq = 1'b0;
        total_cnt++; if (cyc !== 3)
            $display("FAIL midrst_reissue_latency got %0d exp 3", cyc); else pass_cnt++;
        e = sb.pop_front();
        total_cnt++; if (FetchData !== e.data)
            $display("FAIL midrst_data got %h exp %h", FetchData, e.data); else pass_cnt++;
        tick();
    endtask

    task automatic test_wait1_ldr;
        b_DataOpcode = 4'b1101;
        b_DataAddr   = 32'h00000044;
        b_MemRdData  = 32'hCAFEF00D;
        b_DataReq    = 1'b1;
        sb.push_back('{is_data: 1'b1, err: 1'b0, data: 32'hCAFEF00D});
        tick();
        total_cnt++; if (b_MemEn !== 1'b1 || b_RW !== 1'b1 || b_AddressBus !== 32'h44)
            $display("FAIL w1_access got en=%b rw=%b a=%h exp 1 1 44", b_MemEn, b_RW, b_AddressBus); else pass_cnt++;
        tick();
        b_DataReq = 1'b0;
        e = sb.pop_front();
        total_cnt++; if (b_DataGnt !== 1'b1 || b_MemEn !== 1'b0 || b_DataErr !== 1'b0)
            $display("FAIL w1_gnt got dg=%b en=%b err=%b exp 1 0 0", b_DataGnt, b_MemEn, b_DataErr); else pass_cnt++;
        total_cnt++; if (b_DataRdData !== e.data)
            $display("FAIL w1_data got %h exp %h", b_DataRdData, e.data); else pass_cnt++;
        tick();
        total_cnt++; if (b_DataGnt !== 1'b0 || b_Busy !== 1'b0)
            $display("FAIL w1_idle got dg=%b busy=%b exp 0 0", b_DataGnt, b_Busy); else pass_cnt++;
    endtask

    initial begin
        Reset = 1'b1; FetchReq = 1'b0; DataReq = 1'b0;
        FetchAddr = '0; DataAddr = '0; DataWrData = '0; MemRdData = '0; DataOpcode = 4'b1101;
        b_DataReq = 1'b0; b_DataOpcode = 4'b1101; b_DataAddr = '0; b_MemRdData = '0;
        test_reset();
        test_fetch_only();
        test_round_robin();
        test_store();
        test_invalid_op();
        test_reset_mid_access();
        test_wait1_ldr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
